// File: rtl/data_bus_pkg.sv
// Shared types and constants for the data-bus arbiter and its benches.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package data_bus_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_GAP  = 2'd2
    } bus_arb_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } bus_op_t;

    // Master indices
    localparam logic M_CPU = 1'b0;
    localparam logic M_AUX = 1'b1;

    // Bus device selectors (upper address nibble), used by benches
    localparam logic [3:0] DEV_MEM    = 4'h0;
    localparam logic [3:0] DEV_ONCHIP = 4'h1;
    localparam logic [3:0] DEV_IO     = 4'h2;

    // Write wins when a master raises both strobes.
    function automatic bus_op_t op_of(input logic wr);
        return wr ? OP_WRITE : OP_READ;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector: a lone requester wins, a tie goes to the
// master that was not granted last. Latency: combinational.
// Backpressure: none; the caller decides when the grant is consumed.
// Ports: req (request per master), last (previous winner),
//        grant_valid (any request), grant_idx (winning master).
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant_valid,
    output logic       grant_idx
);

    always_comb begin
        grant_valid = |req;
        grant_idx   = 1'b0;
        if (req == 2'b11) begin
            grant_idx = ~last;
        end else begin
            grant_idx = req[1];
        end
    end

endmodule

// File: rtl/data_bus_arbiter.sv
// Shares one data-bus slave port between M0 (pipeline) and M1 (DMA/debug).
// Latency: request seen in IDLE -> strobe next cycle; bus_done -> mk_done next cycle.
// Backpressure: one transaction at a time; losing master holds its request.
// Ports: Clock/Resetn; per master read/write/addr/wdata in, rdata/done/err out;
//        bus_read/bus_write/bus_addr/bus_wdata out, bus_rdata/bus_done in;
//        busy (not idle), owner (current or last granted master).
module data_bus_arbiter
    import data_bus_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 16
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_done,
    output logic              m0_err,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_done,
    output logic              m1_err,
    output logic              bus_read,
    output logic              bus_write,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_done,
    output logic              busy,
    output logic              owner
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    bus_arb_state_t             state_q, state_d;
    bus_op_t                    op_q, op_d;
    logic [ADDR_W-1:0]          addr_q, addr_d;
    logic [DATA_W-1:0]          wdata_q, wdata_d;
    logic                       owner_q, owner_d;
    logic                       last_q, last_d;
    logic [TO_W-1:0]            cnt_q, cnt_d;
    logic [1:0][DATA_W-1:0]     rdata_q, rdata_d;
    logic [1:0]                 done_q, done_d;
    logic [1:0]                 err_q, err_d;

    logic [1:0] req;
    logic       grant_valid;
    logic       grant_idx;

    assign req = {m1_read | m1_write, m0_read | m0_write};

    rr_pick2 u_pick (
        .req         (req),
        .last        (last_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        done_d  = '0;
        err_d   = '0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (grant_valid) begin
                    owner_d = grant_idx;
                    last_d  = grant_idx;
                    if (grant_idx == M_AUX) begin
                        op_d    = op_of(m1_write);
                        addr_d  = m1_addr;
                        wdata_d = m1_wdata;
                    end else begin
                        op_d    = op_of(m0_write);
                        addr_d  = m0_addr;
                        wdata_d = m0_wdata;
                    end
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (bus_done) begin
                    if (op_q == OP_READ) begin
                        rdata_d[owner_q] = bus_rdata;
                    end
                    done_d[owner_q] = 1'b1;
                    state_d         = S_GAP;
                end else if (cnt_q == TO_LAST) begin
                    // Aborted reads return zero so stale data is never mistaken for a result.
                    if (op_q == OP_READ) begin
                        rdata_d[owner_q] = '0;
                    end
                    done_d[owner_q] = 1'b1;
                    err_d[owner_q]  = 1'b1;
                    state_d         = S_GAP;
                end
            end
            S_GAP: begin
                // Requests ignored here: the owner still holds its stale request while it sees done.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            op_q    <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;   // M0 wins the first tie
            cnt_q   <= '0;
            rdata_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Strobes come straight from registers; no path from mk_* to bus_*.
    assign bus_read  = (state_q == S_BUSY) && (op_q == OP_READ);
    assign bus_write = (state_q == S_BUSY) && (op_q == OP_WRITE);
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign busy      = (state_q != S_IDLE);
    assign owner     = owner_q;

    assign m0_rdata = rdata_q[M_CPU];
    assign m1_rdata = rdata_q[M_AUX];
    assign m0_done  = done_q[M_CPU];
    assign m1_done  = done_q[M_AUX];
    assign m0_err   = err_q[M_CPU];
    assign m1_err   = err_q[M_AUX];

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Scoreboard bench for data_bus_arbiter: expectations queued per master at
// request time, popped and compared when that master's done pulses.
// Bus model: done after N strobed cycles, immediate, toggle-style, or never.
module tb_data_bus_arbiter;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int TO = 8;

    typedef struct packed {
        logic          err;
        logic [DW-1:0] rdata;
    } exp_t;

    logic          Clock = 1'b0;
    logic          Resetn = 1'b0;
    logic          m0_read = 1'b0, m0_write = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic [DW-1:0] m0_rdata;
    logic          m0_done, m0_err;
    logic          m1_read = 1'b0, m1_write = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic [DW-1:0] m1_rdata;
    logic          m1_done, m1_err;
    logic          bus_read, bus_write;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata;
    logic          bus_done;
    logic          busy, owner;

    always #5 Clock = ~Clock;

    data_bus_arbiter #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO), .TO_W(16)) dut (
        .Clock(Clock), .Resetn(Resetn),
        .m0_read(m0_read), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_err(m0_err),
        .m1_read(m1_read), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_err(m1_err),
        .bus_read(bus_read), .bus_write(bus_write), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_done(bus_done), .busy(busy), .owner(owner)
    );

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- bus model ----------------
    int            dly_mode = 1;   // >0: done on Nth strobed cycle, 0: never, -1: toggle
    int            strb_cnt = 0;
    logic          tog_q = 1'b0;
    logic [DW-1:0] rd_val = '0;
    wire           strobe = bus_read | bus_write;

    always @(posedge Clock) begin
        strb_cnt <= strobe ? strb_cnt + 1 : 0;
        tog_q    <= strobe ? ~tog_q : 1'b0;
    end

    assign bus_rdata = rd_val;
    assign bus_done  = strobe && ((dly_mode > 0 && strb_cnt == dly_mode - 1) ||
                                  (dly_mode < 0 && tog_q));

    // ---------------- scoreboard / monitor ----------------
    exp_t          q0[$];
    exp_t          q1[$];
    logic [DW-1:0] mdl_rd [2];
    int            order_log[$];
    int            done_cyc_log[$];
    int            cyc = 0;
    int            req_cyc = 0;
    int            rise_cyc [2];
    logic [AW-1:0] rise_addr = '0;
    logic [DW-1:0] rise_wdata = '0;
    logic          run_wr = 1'b0;
    int            run_len = 0;
    logic          strobe_prev = 1'b0;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic score(input int k);
        exp_t          e;
        logic          d, er;
        logic [DW-1:0] rd;
        int            qs;
        d  = (k == 1) ? m1_done : m0_done;
        er = (k == 1) ? m1_err : m0_err;
        rd = (k == 1) ? m1_rdata : m0_rdata;
        qs = (k == 1) ? q1.size() : q0.size();
        if (qs == 0) begin
            chk($sformatf("spurious_done_m%0d", k), 32'(d), 32'(0));
        end else begin
            e = (k == 1) ? q1.pop_front() : q0.pop_front();
            chk($sformatf("err_m%0d", k), 32'(er), 32'(e.err));
            chk($sformatf("rdata_m%0d", k), 32'(rd), 32'(e.rdata));
            chk($sformatf("owner_at_done_m%0d", k), 32'(owner), 32'(k));
            order_log.push_back(k);
            done_cyc_log.push_back(cyc);
        end
    endtask

    always @(negedge Clock) begin
        if (Resetn) begin
            if (strobe) begin
                if (!strobe_prev) begin
                    rise_cyc[owner] = cyc;
                    rise_addr       = bus_addr;
                    rise_wdata      = bus_wdata;
                    run_wr          = bus_write;
                    run_len         = 0;
                end
                run_len++;
            end
            strobe_prev = strobe;
            if (m0_done || m1_done) begin
                chk("one_done_only", 32'(m0_done & m1_done), 32'(0));
                chk("gap_strobe_low", 32'(strobe), 32'(0));
            end
            if (m0_done) score(0);
            if (m1_done) score(1);
        end else begin
            strobe_prev = 1'b0;
        end
    end

    // ---------------- master drivers ----------------
    task automatic put_req(input int k, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic err, input logic [DW-1:0] rv);
        exp_t e;
        e.err = err;
        if (wr) begin
            e.rdata = mdl_rd[k];
        end else begin
            e.rdata   = err ? '0 : rv;
            mdl_rd[k] = e.rdata;
        end
        req_cyc = cyc;
        if (k == 1) begin
            q1.push_back(e);
            m1_read = ~wr; m1_write = wr; m1_addr = a; m1_wdata = wd;
        end else begin
            q0.push_back(e);
            m0_read = ~wr; m0_write = wr; m0_addr = a; m0_wdata = wd;
        end
    endtask

    task automatic finish_txn(input int k);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge Clock);
            seen = (k == 1) ? m1_done : m0_done;
        end
        if (!seen) chk($sformatf("done_wait_m%0d", k), 32'(seen), 32'(1));
        @(posedge Clock);
        #1;
        if (k == 1) begin m1_read = 1'b0; m1_write = 1'b0; end
        else        begin m0_read = 1'b0; m0_write = 1'b0; end
    endtask

    task automatic do_txn(input int k, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic err, input logic [DW-1:0] rv);
        put_req(k, wr, a, wd, err, rv);
        finish_txn(k);
    endtask

    task automatic clear_model();
        q0.delete(); q1.delete();
        order_log.delete(); done_cyc_log.delete();
        mdl_rd[0] = '0; mdl_rd[1] = '0;
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        clear_model();
        repeat (2) @(posedge Clock);
        #1 Resetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: sim did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        clear_model();
        rise_cyc[0] = 0; rise_cyc[1] = 0;
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_strobes", 32'({bus_read, bus_write}), 32'(0));
        chk("rst_owner", 32'(owner), 32'(0));
        chk("rst_addr", 32'(bus_addr), 32'(0));
        chk("rst_done_err", 32'({m0_done, m0_err, m1_done, m1_err}), 32'(0));
        chk("rst_rdata", 32'({m0_rdata, m1_rdata}), 32'(0));
        Resetn = 1'b1;
        @(posedge Clock); #1;

        // Single read with done on the second strobed cycle
        dly_mode = 2; rd_val = 16'hBEEF;
        do_txn(0, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF);
        chk("rd_strobe_len", 32'(run_len), 32'(2));
        chk("rd_addr", 32'(rise_addr), 32'h0010);
        chk("rd_is_read", 32'(run_wr), 32'(0));
        chk("rd_req_to_strobe", 32'(rise_cyc[0] - req_cyc), 32'(1));

        // Tie from reset: M0, then M1, then M0's immediate re-request
        do_reset();
        dly_mode = 2; rd_val = 16'h1234;
        fork
            begin
                do_txn(0, 1'b0, 16'h0100, 16'h0, 1'b0, 16'h1234);
                do_txn(0, 1'b0, 16'h0104, 16'h0, 1'b0, 16'h1234);
            end
            do_txn(1, 1'b0, 16'h0200, 16'h0, 1'b0, 16'h1234);
        join
        chk("tie_count", 32'(order_log.size()), 32'(3));
        if (order_log.size() == 3) begin
            chk("tie_first", 32'(order_log[0]), 32'(0));
            chk("tie_second", 32'(order_log[1]), 32'(1));
            chk("tie_third", 32'(order_log[2]), 32'(0));
            chk("tie_m1_start_after_done", 32'(rise_cyc[1] - done_cyc_log[0]), 32'(2));
        end

        // Immediate-done IO write from M1; rdata must keep the earlier read value
        dly_mode = 1;
        do_txn(1, 1'b1, 16'h2200, 16'h03FF, 1'b0, 16'h0);
        chk("io_strobe_len", 32'(run_len), 32'(1));
        chk("io_is_write", 32'(run_wr), 32'(1));
        chk("io_addr", 32'(rise_addr), 32'h2200);
        chk("io_wdata", 32'(rise_wdata), 32'h03FF);

        // Toggle-done memory, four back-to-back M0 reads
        dly_mode = -1;
        for (int i = 0; i < 4; i++) begin
            rd_val = 16'hA000 + 16'(i);
            do_txn(0, 1'b0, 16'h0300 + 16'(i), 16'h0, 1'b0, 16'hA000 + 16'(i));
            chk($sformatf("tog_len_%0d", i), 32'(run_len), 32'(2));
        end

        // Watchdog: never done on an M1 read
        dly_mode = 0; rd_val = 16'hFFFF;
        do_txn(1, 1'b0, 16'h3000, 16'h0, 1'b1, 16'h0);
        chk("to_strobe_len", 32'(run_len), 32'(TO));
        dly_mode = 2; rd_val = 16'h5A5A;
        do_txn(0, 1'b0, 16'h0020, 16'h0, 1'b0, 16'h5A5A);
        chk("after_to_len", 32'(run_len), 32'(2));

        // Reset in the middle of a BUSY cycle
        dly_mode = 0;
        put_req(0, 1'b0, 16'h0400, 16'h0, 1'b0, 16'h0);
        repeat (3) @(posedge Clock);
        #2 Resetn = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_strobes", 32'({bus_read, bus_write}), 32'(0));
        chk("mid_rst_addr", 32'(bus_addr), 32'(0));
        chk("mid_rst_owner", 32'(owner), 32'(0));
        chk("mid_rst_done", 32'({m0_done, m0_err, m1_done, m1_err}), 32'(0));
        chk("mid_rst_rdata", 32'({m0_rdata, m1_rdata}), 32'(0));
        clear_model();
        dly_mode = 1; rd_val = 16'h7777;
        put_req(0, 1'b0, 16'h0500, 16'h0, 1'b0, 16'h7777);
        put_req(1, 1'b0, 16'h0600, 16'h0, 1'b0, 16'h7777);
        @(posedge Clock); #1 Resetn = 1'b1;
        fork
            finish_txn(0);
            finish_txn(1);
        join
        chk("post_rst_count", 32'(order_log.size()), 32'(2));
        if (order_log.size() == 2) begin
            chk("post_rst_first", 32'(order_log[0]), 32'(0));
            chk("post_rst_second", 32'(order_log[1]), 32'(1));
        end
        repeat (3) @(posedge Clock);
        chk("left_m0", 32'(q0.size()), 32'(0));
        chk("left_m1", 32'(q1.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
